// File: rtl/msk_ring_refresh_pipe_pkg.sv
// Purpose : shared types and helpers for the masked refresh stage and its sibling masked stages.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
package msk_ring_refresh_pipe_pkg;

   // Occupancy of the two-entry output buffer: 0, 1 or 2 words.
   typedef enum logic [1:0] {
      CNT_EMPTY = 2'd0,
      CNT_ONE   = 2'd1,
      CNT_FULL  = 2'd2
   } fifo_cnt_e;

   // Two shares only need one random word: the same mask is added to both shares,
   // so it cancels in the XOR. Wider sharings use one fresh word per share (ring refresh).
   function automatic int rnd_width(input int d, input int w);
      return (d == 2) ? w : d * w;
   endfunction

endpackage

// File: rtl/msk_ring_refresh_pipe_fifo2.sv
// Purpose : two-entry valid/ready register buffer; the head entry is its own flop so pop_dat is never muxed.
// Latency : 1 cycle from push to pop_vld.
// Backpr. : push_rdy is low when both entries are full; it depends only on registered count, never on pop_rdy.
// Ports   : clk, rst (sync, active-high), push_vld/push_rdy/push_dat in, pop_vld/pop_rdy/pop_dat out.
module msk_fifo2
   import msk_ring_refresh_pipe_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_vld,
   output logic             push_rdy,
   input  logic [WIDTH-1:0] push_dat,
   output logic             pop_vld,
   input  logic             pop_rdy,
   output logic [WIDTH-1:0] pop_dat
);

   fifo_cnt_e        count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic             push;
   logic             pop;

   assign push_rdy = (count_q != CNT_FULL);
   assign pop_vld  = (count_q != CNT_EMPTY);
   assign pop_dat  = head_q;
   assign push     = push_vld & push_rdy;
   assign pop      = pop_vld & pop_rdy;

   // Head is always the oldest word. With one word held, a simultaneous push/pop
   // writes the new word straight into the head so count stays at one.
   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (count_q)
         CNT_EMPTY: begin
            if (push) begin
               head_d  = push_dat;
               count_d = CNT_ONE;
            end
         end
         CNT_ONE: begin
            if (push && pop) begin
               head_d = push_dat;
            end else if (push) begin
               tail_d  = push_dat;
               count_d = CNT_FULL;
            end else if (pop) begin
               count_d = CNT_EMPTY;
            end
         end
         CNT_FULL: begin
            if (pop) begin
               head_d  = tail_q;
               count_d = CNT_ONE;
            end
         end
         default: begin
            count_d = CNT_EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= CNT_EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

endmodule

// File: rtl/msk_ring_refresh_pipe.sv
// Purpose : re-randomises every share of a d-share bus and registers it in front of the masked XOR layer.
// Latency : 1 cycle; a word accepted at edge k is presented on out_data right after edge k.
// Backpr. : share bus and randomness are taken together only; both readies drop when the buffer holds two words.
// Ports   : clk, syn_rst; in_valid/in_ready/in_data (d*W); rnd_valid/rnd_ready/rnd (RND_W);
//           out_valid/out_ready/out_data (d*W, flop-driven). Share i sits at bits [i*W +: W].
module msk_ring_refresh_pipe
   import msk_ring_refresh_pipe_pkg::*;
#(
   parameter int   d     = 2,
   parameter int   W     = 32,
   localparam int  RND_W = rnd_width(d, W)
) (
   input  logic             clk,
   input  logic             syn_rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [d*W-1:0]   in_data,
   input  logic             rnd_valid,
   output logic             rnd_ready,
   input  logic [RND_W-1:0] rnd,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [d*W-1:0]   out_data
);

   logic           buf_rdy;
   logic           xfer;
   logic [d*W-1:0] refreshed;

   // buf_rdy comes from the registered occupancy only, so out_ready never reaches the input readies.
   assign in_ready  = rnd_valid & buf_rdy & ~syn_rst;
   assign rnd_ready = in_valid  & buf_rdy & ~syn_rst;
   assign xfer      = in_valid & rnd_valid & buf_rdy & ~syn_rst;

   // Each output share gets two masks (one for d==2, applied to both shares) so the
   // XOR over all shares is unchanged while every individual share is fresh.
   for (genvar i = 0; i < d; i++) begin : g_share
      if (d == 2) begin : g_two
         assign refreshed[i*W +: W] = in_data[i*W +: W] ^ rnd[0 +: W];
      end else begin : g_ring
         assign refreshed[i*W +: W] = in_data[i*W +: W]
                                    ^ rnd[i*W +: W]
                                    ^ rnd[((i + d - 1) % d)*W +: W];
      end
   end

   // The refreshed value is registered before leaving, so upstream glitches cannot
   // combine shares at the XOR gadget inputs.
   msk_fifo2 #(
      .WIDTH (d*W)
   ) u_buf (
      .clk      (clk),
      .rst      (syn_rst),
      .push_vld (xfer),
      .push_rdy (buf_rdy),
      .push_dat (refreshed),
      .pop_vld  (out_valid),
      .pop_rdy  (out_ready),
      .pop_dat  (out_data)
   );

endmodule
